// File: rtl/fpu_arb_pkg.sv
// Shared types and default sizing for the FPU issue arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_CREDITS = 4;

endpackage

// File: rtl/bit_find_first_bit.sv
// Index of the lowest set bit of a vector, plus a found flag.
// Latency: combinational.
// Backpressure: none.
module bit_find_first_bit #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest set bit is the last write and wins
  always_comb begin
    idx   = '0;
    found = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/fpu_issue_arb_rr_pick.sv
// Round-robin pick: first requester at or above ptr, wrapping, as a one-hot select.
// Latency: combinational.
// Backpressure: none; any=0 when nothing is requesting.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] sel,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     ffb_idx;
  logic [IW:0]       sum;

  // Rotate so that position ptr lands at bit 0
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
  end

  bit_find_first_bit #(.N(NREQ), .IW(IW)) u_ffb (
    .vec   (rot),
    .idx   (ffb_idx),
    .found (any)
  );

  // Rotate the found index back into requester numbering
  always_comb begin
    sum = {1'b0, ffb_idx} + {1'b0, ptr};
    if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
    sel = any ? (NREQ'(1) << sum[IW-1:0]) : '0;
  end

endmodule

// File: rtl/fpu_issue_arb.sv
// Round-robin issue arbiter: many beat sources onto one credit-limited FPU pipe input.
// Latency: gnt combinational; winning beat registered onto out_* one cycle later.
// Backpressure: no grant while credits==0; multi-beat ops hold the port until their last beat.
module fpu_issue_arb
  import fpu_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CREDITS = DEF_CREDITS,
  parameter int IW      = $clog2(NREQ),
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*WIDTH-1:0] d_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_vld,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [IW-1:0]         out_src,
  input  logic                  cred_ret,
  output logic [CW-1:0]         credits,
  output logic                  locked,
  output logic                  cred_err
);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    own_q, own_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic             err_q, err_d;
  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [IW-1:0]    out_src_q, out_src_d;

  logic [NREQ-1:0]  pick_sel;
  logic             pick_any;
  logic             grant;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_last;
  logic [WIDTH-1:0] gnt_data;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // Grant: round-robin when idle, owner only when locked, nothing without a credit
  always_comb begin
    gnt = '0;
    if (credits_q != '0) begin
      if (state_q == ST_IDLE) gnt = pick_any ? pick_sel : '0;
      else                    gnt = req & (NREQ'(1) << own_q);
    end
  end

  // Encode the winner and AND-OR mux its beat and last flag
  always_comb begin
    grant    = |gnt;
    gnt_last = |(gnt & last);
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = gnt_idx | IW'(i);
        gnt_data = gnt_data | d_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state: lock/unlock, pointer rotation on last beats, credit accounting
  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    credits_d = credits_q;
    err_d     = err_q;
    if (grant) begin
      if (gnt_last) begin
        state_d = ST_IDLE;
        ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end else begin
        state_d = ST_LOCK;
        own_d   = gnt_idx;
      end
    end
    // A grant only happens with credits>0, so the decrement cannot underflow
    if (grant && !cred_ret) begin
      credits_d = credits_q - CW'(1);
    end else if (!grant && cred_ret) begin
      if (credits_q == CW'(CREDITS)) err_d = 1'b1;
      else                           credits_d = credits_q + CW'(1);
    end
    out_vld_d  = grant;
    out_data_d = gnt_data;
    out_last_d = gnt_last;
    out_src_d  = gnt_idx;
  end

  // All state and the pipe-side output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      own_q      <= '0;
      ptr_q      <= '0;
      credits_q  <= CW'(CREDITS);
      err_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      ptr_q      <= ptr_d;
      credits_q  <= credits_d;
      err_q      <= err_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_src  = out_src_q;
  assign credits  = credits_q;
  assign locked   = (state_q == ST_LOCK);
  assign cred_err = err_q;

endmodule

// File: tb/tb_fpu_issue_arb.sv
// Directed table-driven bench for fpu_issue_arb plus a reset-mid-lock sequence.
// Latency: checks gnt in-cycle and out_* one cycle after the grant.
// Backpressure: exercises credit exhaustion, return and overflow.
module tb_fpu_issue_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   last;
  logic [127:0] d_in;
  logic [3:0]   gnt;
  logic         out_vld;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   out_src;
  logic         cred_ret;
  logic [2:0]   credits;
  logic         locked;
  logic         cred_err;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  assign d_in = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};

  fpu_issue_arb dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .last     (last),
    .d_in     (d_in),
    .gnt      (gnt),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_last (out_last),
    .out_src  (out_src),
    .cred_ret (cred_ret),
    .credits  (credits),
    .locked   (locked),
    .cred_err (cred_err)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       cr;
    logic [3:0] gnt;
    logic [2:0] cred;
    logic       lk;
    logic       vld;
    logic [1:0] src;
    logic       err;
  } vec_t;

  vec_t tv[$];

  function automatic logic [31:0] data_of(input logic [1:0] s);
    case (s)
      2'd0:    return 32'hD0D0_0000;
      2'd1:    return 32'hD1D1_0001;
      2'd2:    return 32'hD2D2_0002;
      default: return 32'hD3D3_0003;
    endcase
  endfunction

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic c,
                     input logic [3:0] g, input logic [2:0] cd, input logic lk,
                     input logic v, input logic [1:0] s, input logic e);
    vec_t x;
    x.req = r; x.last = l; x.cr = c; x.gnt = g; x.cred = cd;
    x.lk = lk; x.vld = v; x.src = s; x.err = e;
    tv.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    //    req    last   cr  | gnt    cred lk vld src err
    // all single-beat: rotate 0..3 until credits run out
    add(4'hF, 4'hF, 1'b0,  4'b0001, 3'd4, 0, 0, 2'd0, 0); // r0
    add(4'hF, 4'hF, 1'b0,  4'b0010, 3'd3, 0, 1, 2'd0, 0);
    add(4'hF, 4'hF, 1'b0,  4'b0100, 3'd2, 0, 1, 2'd1, 0);
    add(4'hF, 4'hF, 1'b0,  4'b1000, 3'd1, 0, 1, 2'd2, 0);
    add(4'hF, 4'hF, 1'b0,  4'b0000, 3'd0, 0, 1, 2'd3, 0); // r4 out of credits
    add(4'hF, 4'hF, 1'b0,  4'b0000, 3'd0, 0, 0, 2'd0, 0);
    add(4'hF, 4'hF, 1'b1,  4'b0000, 3'd0, 0, 0, 2'd0, 0); // r6 return, no comb path
    add(4'hF, 4'hF, 1'b0,  4'b0001, 3'd1, 0, 0, 2'd0, 0); // r7 one credit, one grant
    add(4'hF, 4'hF, 1'b0,  4'b0000, 3'd0, 0, 1, 2'd0, 0); // r8 ptr now 1
    // refill
    add(4'h0, 4'h0, 1'b1,  4'b0000, 3'd0, 0, 0, 2'd0, 0);
    add(4'h0, 4'h0, 1'b1,  4'b0000, 3'd1, 0, 0, 2'd0, 0);
    add(4'h0, 4'h0, 1'b1,  4'b0000, 3'd2, 0, 0, 2'd0, 0);
    add(4'h0, 4'h0, 1'b1,  4'b0000, 3'd3, 0, 0, 2'd0, 0);
    add(4'h0, 4'h0, 1'b0,  4'b0000, 3'd4, 0, 0, 2'd0, 0); // r13
    // grant 1 to move ptr to 2, then 3-beat op from requester 2
    add(4'hF, 4'hF, 1'b0,  4'b0010, 3'd4, 0, 0, 2'd0, 0); // r14
    add(4'hF, 4'b1011, 1'b0, 4'b0100, 3'd3, 0, 1, 2'd1, 0);
    add(4'hF, 4'b1011, 1'b1, 4'b0100, 3'd2, 1, 1, 2'd2, 0); // grant + return
    add(4'hF, 4'hF, 1'b1,  4'b0100, 3'd2, 1, 1, 2'd2, 0);   // last beat
    add(4'hF, 4'hF, 1'b0,  4'b1000, 3'd2, 0, 1, 2'd2, 0);   // r18 ptr=3
    add(4'h0, 4'h0, 1'b1,  4'b0000, 3'd1, 0, 1, 2'd3, 0);
    // owner drops req mid-lock; others must be ignored
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 3'd2, 0, 0, 2'd0, 0); // r20
    add(4'b1110, 4'hF, 1'b0, 4'b0000, 3'd2, 1, 1, 2'd0, 0);
    add(4'b1110, 4'hF, 1'b0, 4'b0000, 3'd2, 1, 0, 2'd0, 0);
    add(4'b0001, 4'b0001, 1'b1, 4'b0001, 3'd2, 1, 0, 2'd0, 0); // r23 resume, last
    // refill to full then overflow
    add(4'h0, 4'h0, 1'b1,  4'b0000, 3'd2, 0, 1, 2'd0, 0);
    add(4'h0, 4'h0, 1'b1,  4'b0000, 3'd3, 0, 0, 2'd0, 0);
    add(4'h0, 4'h0, 1'b1,  4'b0000, 3'd4, 0, 0, 2'd0, 0); // r26 overflow
    add(4'h0, 4'h0, 1'b0,  4'b0000, 3'd4, 0, 0, 2'd0, 1);
    add(4'b0100, 4'b0100, 1'b0, 4'b0100, 3'd4, 0, 0, 2'd0, 1); // r28 sticky

    rst = 1'b0; req = '0; last = '0; cred_ret = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst gnt", 32'(gnt), 32'h0);
    chk("rst out_vld", 32'(out_vld), 32'h0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst out_last", 32'(out_last), 32'h0);
    chk("rst credits", 32'(credits), 32'd4);
    chk("rst cred_err", 32'(cred_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      req = tv[i].req; last = tv[i].last; cred_ret = tv[i].cr;
      #1;
      chk($sformatf("r%0d gnt", i),      32'(gnt),      32'(tv[i].gnt));
      chk($sformatf("r%0d credits", i),  32'(credits),  32'(tv[i].cred));
      chk($sformatf("r%0d locked", i),   32'(locked),   32'(tv[i].lk));
      chk($sformatf("r%0d out_vld", i),  32'(out_vld),  32'(tv[i].vld));
      chk($sformatf("r%0d out_src", i),  32'(out_src),  32'(tv[i].src));
      chk($sformatf("r%0d cred_err", i), 32'(cred_err), 32'(tv[i].err));
      if (tv[i].vld) chk($sformatf("r%0d out_data", i), out_data, data_of(tv[i].src));
    end

    // requester 1 starts a multi-beat op, then reset lands mid-lock
    @(negedge clk);
    req = 4'b0010; last = 4'b0000; cred_ret = 1'b0;
    #1;
    chk("seq gnt1", 32'(gnt), 32'b0010);
    chk("seq r28 out_last", 32'(out_last), 32'h1);
    chk("seq r28 out_data", out_data, 32'hD2D2_0002);
    @(posedge clk);
    #1;
    chk("seq lock", 32'(locked), 32'h1);
    chk("seq vld", 32'(out_vld), 32'h1);
    chk("seq src", 32'(out_src), 32'd1);
    chk("seq last0", 32'(out_last), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst out_vld", 32'(out_vld), 32'h0);
    chk("arst locked", 32'(locked), 32'h0);
    chk("arst credits", 32'(credits), 32'd4);
    chk("arst cred_err", 32'(cred_err), 32'h0);
    @(negedge clk);
    rst = 1'b1; req = 4'hF; last = 4'hF;
    #1;
    chk("post rst gnt", 32'(gnt), 32'b0001);
    @(posedge clk);
    #1;
    chk("post rst vld", 32'(out_vld), 32'h1);
    chk("post rst src", 32'(out_src), 32'd0);
    chk("post rst data", out_data, 32'hD0D0_0000);
    chk("post rst last", 32'(out_last), 32'h1);
    chk("post rst credits", 32'(credits), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
